id_stage: RTL and testbench

- Decode stage directly downstream of the fetch stage. Consumes `inst` and `pc_calc` from fetch.
- Holds the IF/ID latch, a 4x8-bit register file with a writeback port, hazard interlock, and branch/jump resolution.
- Drives `pcj_mux`/`choice_mux` back to fetch and a registered ID/EX bundle to execute.
- Instruction format: `[7:4]` opcode, `[3:2]` ra, `[1:0]` rb.

---
 rtl/id_stage_if.sv | 33 +++
 rtl/id_stage.sv | 143 ++++++++++++++
 tb/tb_id_stage.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/id_stage_if.sv
// rtl/id_stage_if.sv - fetch, execute-feedback, writeback and ID/EX signals of the decode stage
interface id_stage_if;
  logic       [7:0] inst;
  logic       [7:0] pc_calc;
  logic             ex_wr_en;
  logic       [1:0] ex_wr_addr;
  logic             ex_is_load;
  logic             wb_en;
  logic       [1:0] wb_addr;
  logic       [7:0] wb_data;
  logic             stall_if;
  logic       [7:0] pcj_mux;
  logic             choice_mux;
  logic             idex_valid;
  logic       [3:0] idex_op;
  logic       [1:0] idex_ra;
  logic       [1:0] idex_rb;
  logic       [7:0] idex_va;
  logic       [7:0] idex_vb;
  logic       [7:0] idex_pc;

  modport slave (
    input  inst, pc_calc, ex_wr_en, ex_wr_addr, ex_is_load, wb_en, wb_addr, wb_data,
    output stall_if, pcj_mux, choice_mux,
    output idex_valid, idex_op, idex_ra, idex_rb, idex_va, idex_vb, idex_pc
  );

  modport master (
    output inst, pc_calc, ex_wr_en, ex_wr_addr, ex_is_load, wb_en, wb_addr, wb_data,
    input  stall_if, pcj_mux, choice_mux,
    input  idex_valid, idex_op, idex_ra, idex_rb, idex_va, idex_vb, idex_pc
  );
endinterface

// File: rtl/id_stage.sv
// rtl/id_stage.sv - decode stage: IF/ID latch, 4x8 register file, interlock, branch resolution, ID/EX register
module id_stage #(
  parameter int         NREG     = 4,
  parameter logic [7:0] RESET_PC = 8'h00
) (
  input  logic      clock,
  input  logic      reset_n,
  id_stage_if.slave bus
);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_LW   = 4'd5;
  localparam logic [3:0] OP_SW   = 4'd6;
  localparam logic [3:0] OP_BEQZ = 4'd8;
  localparam logic [3:0] OP_JR   = 4'd9;

  logic [7:0] if_inst;
  logic [7:0] if_pc;
  logic       if_valid;
  logic [7:0] regs [NREG];

  logic [3:0] op;
  logic [1:0] ra;
  logic [1:0] rb;
  logic [7:0] va;
  logic [7:0] vb;
  logic       uses_ra;
  logic       uses_rb;
  logic       is_branch;
  logic       known;
  logic       hit_ra;
  logic       hit_rb;
  logic       stall;
  logic       take;
  logic [7:0] pcj;

  logic       idex_valid_q;
  logic [3:0] idex_op_q;
  logic [1:0] idex_ra_q;
  logic [1:0] idex_rb_q;
  logic [7:0] idex_va_q;
  logic [7:0] idex_vb_q;
  logic [7:0] idex_pc_q;

  assign op = if_inst[7:4];
  assign ra = if_inst[3:2];
  assign rb = if_inst[1:0];

  // Write-through: a same-cycle writeback is visible to the decode read
  assign va = (bus.wb_en && bus.wb_addr == ra) ? bus.wb_data : regs[ra];
  assign vb = (bus.wb_en && bus.wb_addr == rb) ? bus.wb_data : regs[rb];

  always_comb begin
    uses_ra   = 1'b0;
    uses_rb   = 1'b0;
    is_branch = 1'b0;
    known     = 1'b1;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SW: begin
        uses_ra = 1'b1;
        uses_rb = 1'b1;
      end
      OP_LW:   uses_rb = 1'b1;
      OP_BEQZ: begin
        uses_ra   = 1'b1;
        uses_rb   = 1'b1;
        is_branch = 1'b1;
      end
      OP_JR: begin
        uses_ra   = 1'b1;
        is_branch = 1'b1;
      end
      OP_NOP:  known = 1'b0;
      default: known = 1'b0;
    endcase
  end

  assign hit_ra = uses_ra && (bus.ex_wr_addr == ra);
  assign hit_rb = uses_rb && (bus.ex_wr_addr == rb);

  // Branches resolve here without forwarding, so any pending EX write to a source interlocks
  assign stall = if_valid && bus.ex_wr_en && (hit_ra || hit_rb) && (bus.ex_is_load || is_branch);

  assign take = if_valid && !stall && ((op == OP_JR) || (op == OP_BEQZ && va == 8'h00));
  assign pcj  = !take ? 8'h00 : (op == OP_JR) ? va : vb;

  assign bus.stall_if   = stall;
  assign bus.choice_mux = take;
  assign bus.pcj_mux    = pcj;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      if_inst  <= 8'h00;
      if_pc    <= RESET_PC;
      if_valid <= 1'b0;
    end else if (!stall) begin
      if_inst  <= bus.inst;
      if_pc    <= bus.pc_calc;
      if_valid <= !take;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) regs[i] <= 8'h00;
    end else if (bus.wb_en) begin
      regs[bus.wb_addr] <= bus.wb_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n || stall) begin
      idex_valid_q <= 1'b0;
      idex_op_q    <= 4'h0;
      idex_ra_q    <= 2'b00;
      idex_rb_q    <= 2'b00;
      idex_va_q    <= 8'h00;
      idex_vb_q    <= 8'h00;
      idex_pc_q    <= 8'h00;
    end else begin
      idex_valid_q <= if_valid && known;
      idex_op_q    <= op;
      idex_ra_q    <= ra;
      idex_rb_q    <= rb;
      idex_va_q    <= va;
      idex_vb_q    <= vb;
      idex_pc_q    <= if_pc;
    end
  end

  assign bus.idex_valid = idex_valid_q;
  assign bus.idex_op    = idex_op_q;
  assign bus.idex_ra    = idex_ra_q;
  assign bus.idex_rb    = idex_rb_q;
  assign bus.idex_va    = idex_va_q;
  assign bus.idex_vb    = idex_vb_q;
  assign bus.idex_pc    = idex_pc_q;

endmodule

// File: tb/tb_id_stage.sv
// tb/tb_id_stage.sv - directed bench for id_stage with a per-cycle reference model
module tb_id_stage;
  logic clock;
  logic reset_n;
  id_stage_if bus ();

  id_stage #(.NREG(4), .RESET_PC(8'h00)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int tests = 0;
  int fails = 0;
  logic cmp_en = 1'b0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural state plus the expected ID/EX slot
  logic [7:0] m_r [4];
  logic [7:0] m_inst;
  logic [7:0] m_pc;
  logic       m_v;
  logic       e_v;
  logic       e_zero;
  logic [3:0] e_op;
  logic [1:0] e_ra;
  logic [1:0] e_rb;
  logic [7:0] e_va;
  logic [7:0] e_vb;
  logic [7:0] e_pc;

  function automatic logic [7:0] rd(input logic [1:0] a);
    if (bus.wb_en && bus.wb_addr == a) return bus.wb_data;
    return m_r[a];
  endfunction

  function automatic logic exp_stall();
    logic [3:0] o;
    logic       src_a;
    logic       src_b;
    logic       hit;
    o     = m_inst[7:4];
    src_a = o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd6, 4'd8, 4'd9};
    src_b = o inside {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8};
    hit   = (src_a && bus.ex_wr_addr == m_inst[3:2]) || (src_b && bus.ex_wr_addr == m_inst[1:0]);
    return m_v && bus.ex_wr_en && hit && (bus.ex_is_load || o == 4'd8 || o == 4'd9);
  endfunction

  function automatic logic exp_take();
    if (!m_v || exp_stall()) return 1'b0;
    if (m_inst[7:4] == 4'd9) return 1'b1;
    return (m_inst[7:4] == 4'd8) && (rd(m_inst[3:2]) == 8'h00);
  endfunction

  function automatic logic [7:0] exp_pcj();
    if (!exp_take()) return 8'h00;
    return (m_inst[7:4] == 4'd9) ? rd(m_inst[3:2]) : rd(m_inst[1:0]);
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) m_r[i] <= 8'h00;
      m_inst <= 8'h00; m_pc <= 8'h00; m_v <= 1'b0;
      e_v <= 1'b0; e_zero <= 1'b1;
      e_op <= 4'h0; e_ra <= 2'b00; e_rb <= 2'b00;
      e_va <= 8'h00; e_vb <= 8'h00; e_pc <= 8'h00;
    end else begin
      if (exp_stall()) begin
        e_v <= 1'b0; e_zero <= 1'b1;
        e_op <= 4'h0; e_ra <= 2'b00; e_rb <= 2'b00;
        e_va <= 8'h00; e_vb <= 8'h00; e_pc <= 8'h00;
      end else begin
        e_v    <= m_v && (m_inst[7:4] inside {[4'd1:4'd6], 4'd8, 4'd9});
        e_zero <= 1'b0;
        e_op   <= m_inst[7:4];
        e_ra   <= m_inst[3:2];
        e_rb   <= m_inst[1:0];
        e_va   <= rd(m_inst[3:2]);
        e_vb   <= rd(m_inst[1:0]);
        e_pc   <= m_pc;
        m_inst <= bus.inst;
        m_pc   <= bus.pc_calc;
        m_v    <= !exp_take();
      end
      if (bus.wb_en) m_r[bus.wb_addr] <= bus.wb_data;
    end
  end

  always @(negedge clock) begin
    if (cmp_en) begin
      check("stall_if", {7'd0, bus.stall_if}, {7'd0, exp_stall()});
      check("choice_mux", {7'd0, bus.choice_mux}, {7'd0, exp_take()});
      check("pcj_mux", bus.pcj_mux, exp_pcj());
      check("idex_valid", {7'd0, bus.idex_valid}, {7'd0, e_v});
      if (e_v || e_zero) begin
        check("idex_op", {4'd0, bus.idex_op}, {4'd0, e_op});
        check("idex_ra", {6'd0, bus.idex_ra}, {6'd0, e_ra});
        check("idex_rb", {6'd0, bus.idex_rb}, {6'd0, e_rb});
        check("idex_va", bus.idex_va, e_va);
        check("idex_vb", bus.idex_vb, e_vb);
        check("idex_pc", bus.idex_pc, e_pc);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #2;
  endtask

  task automatic set_wb(input logic en, input logic [1:0] a, input logic [7:0] d);
    bus.wb_en = en; bus.wb_addr = a; bus.wb_data = d;
  endtask

  task automatic set_ex(input logic en, input logic [1:0] a, input logic ld);
    bus.ex_wr_en = en; bus.ex_wr_addr = a; bus.ex_is_load = ld;
  endtask

  task automatic fetch(input logic [7:0] i, input logic [7:0] p);
    bus.inst = i; bus.pc_calc = p;
  endtask

  initial begin
    reset_n = 1'b0;
    fetch(8'h00, 8'h00);
    set_wb(1'b0, 2'd0, 8'h00);
    set_ex(1'b0, 2'd0, 1'b0);
    cyc(); cyc();
    check("rst idex_valid", {7'd0, bus.idex_valid}, 8'h00);
    check("rst stall_if", {7'd0, bus.stall_if}, 8'h00);
    check("rst choice_mux", {7'd0, bus.choice_mux}, 8'h00);
    check("rst pcj_mux", bus.pcj_mux, 8'h00);
    check("rst idex_pc", bus.idex_pc, 8'h00);
    cmp_en  = 1'b1;
    reset_n = 1'b1;

    // ADD r1,r2 with R1=05, R2=03
    set_wb(1'b1, 2'd1, 8'h05); cyc();
    set_wb(1'b1, 2'd2, 8'h03); cyc();
    set_wb(1'b0, 2'd0, 8'h00); fetch(8'h16, 8'h04); cyc();
    fetch(8'h00, 8'h05); cyc();
    check("add valid", {7'd0, bus.idex_valid}, 8'h01);
    check("add op", {4'd0, bus.idex_op}, 8'h01);
    check("add ra", {6'd0, bus.idex_ra}, 8'h01);
    check("add rb", {6'd0, bus.idex_rb}, 8'h02);
    check("add va", bus.idex_va, 8'h05);
    check("add vb", bus.idex_vb, 8'h03);
    check("add pc", bus.idex_pc, 8'h04);

    // Write-through bypass onto the rb operand of 1B
    fetch(8'h1B, 8'h08); cyc();
    set_wb(1'b1, 2'd3, 8'hAA); fetch(8'h00, 8'h09); cyc();
    check("bypass vb", bus.idex_vb, 8'hAA);
    check("bypass va", bus.idex_va, 8'h03);
    set_wb(1'b0, 2'd0, 8'h00);

    // Load-use interlock on rb
    fetch(8'h16, 8'h0C); cyc();
    fetch(8'h00, 8'h0D); set_ex(1'b1, 2'd2, 1'b1); #1;
    check("lu stall", {7'd0, bus.stall_if}, 8'h01);
    cyc();
    check("lu bubble", {7'd0, bus.idex_valid}, 8'h00);
    set_ex(1'b0, 2'd0, 1'b0); #1;
    check("lu release", {7'd0, bus.stall_if}, 8'h00);
    cyc();
    check("lu issue valid", {7'd0, bus.idex_valid}, 8'h01);
    check("lu issue pc", bus.idex_pc, 8'h0C);
    check("lu issue va", bus.idex_va, 8'h05);

    // Taken BEQZ r0,r3 with R3=40 written alongside the fetch
    set_wb(1'b1, 2'd3, 8'h40); fetch(8'h83, 8'h10); cyc();
    set_wb(1'b0, 2'd0, 8'h00); fetch(8'h55, 8'h11); #1;
    check("beqz choice", {7'd0, bus.choice_mux}, 8'h01);
    check("beqz pcj", bus.pcj_mux, 8'h40);
    cyc();
    check("beqz advances", {4'd0, bus.idex_op}, 8'h08);
    fetch(8'h00, 8'h40); cyc();
    check("flushed slot", {7'd0, bus.idex_valid}, 8'h00);

    // Not-taken BEQZ, then JR r0 held by a pending EX write to r0
    set_wb(1'b1, 2'd0, 8'h01); cyc();
    set_wb(1'b0, 2'd0, 8'h00); fetch(8'h83, 8'h14); cyc(); #1;
    check("beqz not taken", {7'd0, bus.choice_mux}, 8'h00);
    fetch(8'h90, 8'h15); cyc();
    fetch(8'h00, 8'h16); set_ex(1'b1, 2'd0, 1'b0); #1;
    check("jr stall", {7'd0, bus.stall_if}, 8'h01);
    check("jr held", {7'd0, bus.choice_mux}, 8'h00);
    cyc();
    set_ex(1'b0, 2'd0, 1'b0); #1;
    check("jr choice", {7'd0, bus.choice_mux}, 8'h01);
    check("jr pcj", bus.pcj_mux, 8'h01);
    cyc();

    // Unknown opcode yields an empty slot
    fetch(8'h70, 8'h30); cyc();
    fetch(8'h00, 8'h31); cyc();
    check("unknown op", {7'd0, bus.idex_valid}, 8'h00);

    // Asynchronous reset in the middle of a stall
    fetch(8'h16, 8'h40); cyc();
    fetch(8'h00, 8'h41); set_ex(1'b1, 2'd1, 1'b1); #1;
    check("pre-reset stall", {7'd0, bus.stall_if}, 8'h01);
    #1 reset_n = 1'b0; #1;
    check("async stall", {7'd0, bus.stall_if}, 8'h00);
    check("async valid", {7'd0, bus.idex_valid}, 8'h00);
    check("async pc", bus.idex_pc, 8'h00);
    check("async va", bus.idex_va, 8'h00);
    set_ex(1'b0, 2'd0, 1'b0);
    cyc();
    reset_n = 1'b1; fetch(8'h16, 8'h20); cyc();
    fetch(8'h00, 8'h21); cyc();
    check("post-reset valid", {7'd0, bus.idex_valid}, 8'h01);
    check("post-reset va", bus.idex_va, 8'h00);
    check("post-reset vb", bus.idex_vb, 8'h00);
    check("post-reset pc", bus.idex_pc, 8'h20);
    cyc(); cyc();

    cmp_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
